// File: rtl/pushbutton_bank.sv
// N-channel pushbutton conditioner: sync, debounce, press/release pulses.
// Optional auto-repeat engine compiled in with `define PB_AUTOREPEAT_EN.
module pushbutton_bank #(
  parameter int N            = 4,
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_p,
  output logic [N-1:0] rpt,
  output logic         any_press
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  logic [N-1:0]  sync1_q;
  logic [N-1:0]  s_q;
  logic [N-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  logic [N-1:0]  level_q;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q, rel_d;
  logic          any_q, any_d;

  logic [N-1:0]  rise, fall, fire;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        deb_d[i] = s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // deb_q is the internal decision; level_q trails it by one stage
  // so the edge detect below yields registered one-cycle pulses.
  assign rise = deb_q & ~level_q;
  assign fall = ~deb_q & level_q;

  always_comb begin
    press_d = rise | fire;
    rel_d   = fall;
    any_d   = |press_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s_q     <= '0;
      deb_q   <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= in;
      s_q     <= sync1_q;
      deb_q   <= deb_d;
      level_q <= deb_q;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= any_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  logic [1:0]    st_q [N];
  logic [1:0]    st_d [N];
  logic [RW-1:0] rc_q [N];
  logic [RW-1:0] rc_d [N];
  logic [N-1:0]  rpt_q;

  always_comb begin
    fire = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
      rc_d[i] = '0;
      unique case (st_q[i])
        ST_IDLE: begin
          if (rise[i]) st_d[i] = ST_DELAY;
        end
        ST_DELAY: begin
          // a pending release wins over a due repeat pulse
          if (fall[i] || !level_q[i]) begin
            st_d[i] = ST_IDLE;
          end else if (rc_q[i] == RW'(REPEAT_DELAY - 1)) begin
            fire[i] = 1'b1;
            st_d[i] = ST_RPT;
          end else begin
            rc_d[i] = rc_q[i] + 1'b1;
          end
        end
        ST_RPT: begin
          if (fall[i] || !level_q[i]) begin
            st_d[i] = ST_IDLE;
          end else if (rc_q[i] == RW'(REPEAT_RATE - 1)) begin
            fire[i] = 1'b1;
          end else begin
            rc_d[i] = rc_q[i] + 1'b1;
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q <= '0;
      for (int i = 0; i < N; i++) begin
        st_q[i] <= ST_IDLE;
        rc_q[i] <= '0;
      end
    end else begin
      rpt_q <= fire;
      for (int i = 0; i < N; i++) begin
        st_q[i] <= st_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  assign rpt = rpt_q;
`else
  assign fire = '0;
  assign rpt  = '0;
`endif

  assign level     = level_q;
  assign press     = press_q;
  assign release_p = rel_q;
  assign any_press = any_q;

endmodule

// File: tb/tb_pushbutton_bank.sv
// Scoreboard bench for pushbutton_bank (N=4, DB_CYCLES=16).
// Expected pulse events are queued by the driver and popped by a monitor.
module tb_pushbutton_bank;

  localparam int LAT = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_r = 4'h0;
  logic [3:0] level, press, rel, rpt;
  logic       any_press;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] lv;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
  } ev_t;

  ev_t q[$];

  pushbutton_bank #(
    .N(4), .DB_CYCLES(16), .REPEAT_DELAY(100), .REPEAT_RATE(20)
  ) dut (
    .clk(clk), .rst(rst), .in(in_r),
    .level(level), .press(press), .release_p(rel),
    .rpt(rpt), .any_press(any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (rst && (((press | rel | rpt) != 4'h0) || any_press)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d lv=%b pr=%b rl=%b rp=%b any=%b, required no event",
                 cyc, level, press, rel, rpt, any_press);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || level !== e.lv || press !== e.pr ||
            rel !== e.rl || rpt !== e.rp || any_press !== (|e.pr)) begin
          errors++;
          $display("FAIL event: got cyc=%0d lv=%b pr=%b rl=%b rp=%b any=%b, required cyc=%0d lv=%b pr=%b rl=%b rp=%b any=%b",
                   cyc, level, press, rel, rpt, any_press,
                   e.cyc, e.lv, e.pr, e.rl, e.rp, |e.pr);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v, output int k);
    in_r = v;
    k = cyc + 1;
  endtask

  function automatic void push(input int c, input logic [3:0] lv,
                               input logic [3:0] pr, input logic [3:0] rl,
                               input logic [3:0] rp);
    ev_t e;
    e.cyc = c; e.lv = lv; e.pr = pr; e.rl = rl; e.rp = rp;
    q.push_back(e);
  endfunction

  task automatic chk_zero(input string name);
    checks++;
    if ({level, press, rel, rpt, any_press} !== 17'h0) begin
      errors++;
      $display("FAIL %s: lv=%b pr=%b rl=%b rp=%b any=%b, required all 0",
               name, level, press, rel, rpt, any_press);
    end
  endtask

  initial begin
    int k, k2, p;
    rst  = 1'b0;
    in_r = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_zero("reset_hold");
    end

    // held buttons across reset release
    rst = 1'b1;
    k = cyc + 1;
    push(k + LAT, 4'hF, 4'hF, 4'h0, 4'h0);
    tick(20);

    set_in(4'b1000, k);
    push(k + LAT, 4'b1000, 4'h0, 4'b0111, 4'h0);
    tick(20);

    // simultaneous rise on ch2 and fall on ch3
    set_in(4'b0100, k);
    push(k + LAT, 4'b0100, 4'b0100, 4'b1000, 4'h0);
    tick(20);
    set_in(4'b0000, k);
    push(k + LAT, 4'h0, 4'h0, 4'b0100, 4'h0);
    tick(20);

    // clean press/release on ch0
    set_in(4'b0001, k);
    push(k + LAT, 4'b0001, 4'b0001, 4'h0, 4'h0);
    tick(20);
    set_in(4'b0000, k);
    push(k + LAT, 4'h0, 4'h0, 4'b0001, 4'h0);
    tick(20);

    // bounce on ch1: 1,0,1 in 5-cycle segments then hold
    set_in(4'b0010, k);
    tick(5);
    set_in(4'b0000, k);
    tick(5);
    set_in(4'b0010, k);
    push(k + LAT, 4'b0010, 4'b0010, 4'h0, 4'h0);
    tick(20);
    set_in(4'b0000, k);
    push(k + LAT, 4'h0, 4'h0, 4'b0010, 4'h0);
    tick(20);

    // 15-cycle glitch is rejected
    set_in(4'b0001, k);
    tick(15);
    set_in(4'b0000, k);
    tick(40);

    // 16-cycle pulse is just long enough
    set_in(4'b0001, k);
    push(k + LAT, 4'b0001, 4'b0001, 4'h0, 4'h0);
    tick(16);
    set_in(4'b0000, k2);
    push(k2 + LAT, 4'h0, 4'h0, 4'b0001, 4'h0);
    tick(40);

    // long hold on ch0; release lands exactly where +200 repeat would be
    set_in(4'b0001, k);
    p = k + LAT;
    push(p, 4'b0001, 4'b0001, 4'h0, 4'h0);
`ifdef PB_AUTOREPEAT_EN
    for (int j = 0; j < 5; j++)
      push(p + 100 + 20 * j, 4'b0001, 4'b0001, 4'h0, 4'b0001);
`endif
    tick(200);
    set_in(4'b0000, k);
    push(k + LAT, 4'h0, 4'h0, 4'b0001, 4'h0);
    tick(150);

    // reset mid-debounce with ch3 already level-high
    set_in(4'b1000, k);
    push(k + LAT, 4'b1000, 4'b1000, 4'h0, 4'h0);
    tick(20);
    set_in(4'b1001, k);
    tick(12);
    rst = 1'b0;
    #1;
    chk_zero("reset_mid");
    tick(3);
    chk_zero("reset_mid_hold");
    rst = 1'b1;
    k = cyc + 1;
    push(k + LAT, 4'b1001, 4'b1001, 4'h0, 4'h0);
    tick(20);
    set_in(4'b0000, k);
    push(k + LAT, 4'h0, 4'h0, 4'b1001, 4'h0);
    tick(30);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left (next cyc=%0d), required 0",
               q.size(), q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
